branch_target_buffer: RTL and testbench



---
 rtl/branch_target_buffer_pkg.sv | 18 +
 rtl/branch_target_buffer_entry_ram.sv | 20 ++
 rtl/branch_target_buffer.sv | 80 ++++++++
 tb/tb_branch_target_buffer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/branch_target_buffer_pkg.sv
// branch_target_buffer_pkg: shared BTB types; the ctr field exists only with BTB_TWO_BIT_COUNTER_EN
package branch_target_buffer_pkg;
  localparam int BTB_ENTRY_NUM = 64;
  typedef logic [29:0] btb_tag_t;
  typedef logic [$clog2(BTB_ENTRY_NUM)-1:0] btb_index_t;
  typedef enum logic {INIT, RUN} btb_state_t;
  typedef struct packed {
    logic valid;
    btb_tag_t tag;
    logic [31:0] target;
`ifdef BTB_TWO_BIT_COUNTER_EN
    logic [1:0] ctr;
`endif
  } btb_entry_t;
  function automatic btb_tag_t tag_of(input logic [31:0] a, input int index_w);
    return btb_tag_t'(a >> (index_w + 2));
  endfunction
endpackage

// File: rtl/branch_target_buffer_entry_ram.sv
// btb_entry_ram: entry table with one synchronous write port and two asynchronous read ports
import branch_target_buffer_pkg::*;
module btb_entry_ram #(
  parameter int ENTRY_NUM = BTB_ENTRY_NUM,
  parameter int INDEX_W = $clog2(ENTRY_NUM)
) (
  input logic clk,
  input logic we,
  input logic [INDEX_W-1:0] waddr,
  input btb_entry_t wdata,
  input logic [INDEX_W-1:0] raddr_a,
  output btb_entry_t rdata_a,
  input logic [INDEX_W-1:0] raddr_b,
  output btb_entry_t rdata_b
);
  btb_entry_t mem [ENTRY_NUM];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with init sweep, update RMW and lookup/hit counters; BTB_TWO_BIT_COUNTER_EN adds 2-bit taken counters
import branch_target_buffer_pkg::*;
module branch_target_buffer #(
  parameter int ENTRY_NUM = BTB_ENTRY_NUM
) (
  input logic clk,
  input logic rst,
  input logic [31:0] pc,
  input logic stall,
  output logic btbHit,
  output logic [31:0] btbPredictedPc,
  input logic updateValid,
  input logic [31:0] updatePc,
  input logic [31:0] updateTarget,
  input logic updateTaken,
  output logic ready,
  output logic [31:0] lookupCount,
  output logic [31:0] hitCount
);
  localparam int INDEX_W = $clog2(ENTRY_NUM);
  btb_state_t state, state_n;
  logic [INDEX_W-1:0] sweep, waddr;
  btb_entry_t lk, up, wdata;
  logic we, lk_match, up_match, taken_pred;
  btb_entry_ram #(.ENTRY_NUM(ENTRY_NUM), .INDEX_W(INDEX_W)) ram (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr_a(pc[INDEX_W+1:2]),
    .rdata_a(lk),
    .raddr_b(updatePc[INDEX_W+1:2]),
    .rdata_b(up)
  );
  always_ff @(posedge clk) begin
    state <= rst ? INIT : state_n;
    sweep <= (rst || state == RUN) ? '0 : sweep + INDEX_W'(1);
  end
  always_comb begin
    state_n = (state == INIT && sweep == INDEX_W'(ENTRY_NUM - 1)) ? RUN : state;
    ready = state == RUN;
  end
  always_comb begin
    lk_match = lk.valid && lk.tag == tag_of(pc, INDEX_W);
`ifdef BTB_TWO_BIT_COUNTER_EN
    taken_pred = lk.ctr[1];
`else
    taken_pred = 1'b1;
`endif
    btbHit = ready && lk_match && taken_pred;
    btbPredictedPc = btbHit ? lk.target : '0;
  end
  always_comb begin
    up_match = up.valid && up.tag == tag_of(updatePc, INDEX_W);
    we = ready ? updateValid && (updateTaken || up_match) : 1'b1;
    waddr = ready ? updatePc[INDEX_W+1:2] : sweep;
    wdata = up;
    if (updateTaken) begin
      wdata.valid = 1'b1;
      wdata.tag = tag_of(updatePc, INDEX_W);
      wdata.target = updateTarget;
    end
`ifdef BTB_TWO_BIT_COUNTER_EN
    wdata.ctr = !updateTaken ? (up.ctr == 2'b00 ? 2'b00 : up.ctr - 2'd1) :
                !up_match ? 2'b10 : up.ctr == 2'b11 ? 2'b11 : up.ctr + 2'd1;
`else
    if (!updateTaken) wdata.valid = 1'b0;
`endif
    if (!ready) wdata = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lookupCount <= '0;
      hitCount <= '0;
    end else if (ready && !stall) begin
      lookupCount <= lookupCount + 32'd1;
      hitCount <= hitCount + 32'(btbHit);
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: table-driven, directed and randomized checks against a behavioural BTB model
module tb_branch_target_buffer;
  localparam int N = 64;
`ifdef BTB_TWO_BIT_COUNTER_EN
  localparam bit CTR = 1'b1;
`else
  localparam bit CTR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, updateValid = 1'b0, updateTaken = 1'b0;
  logic [31:0] pc = '0, updatePc = '0, updateTarget = '0;
  logic btbHit, ready;
  logic [31:0] btbPredictedPc, lookupCount, hitCount;
  always #5 clk = ~clk;
  branch_target_buffer #(.ENTRY_NUM(N)) dut (
    .clk(clk), .rst(rst), .pc(pc), .stall(stall), .btbHit(btbHit),
    .btbPredictedPc(btbPredictedPc), .updateValid(updateValid), .updatePc(updatePc),
    .updateTarget(updateTarget), .updateTaken(updateTaken), .ready(ready),
    .lookupCount(lookupCount), .hitCount(hitCount)
  );
  int errs = 0, checks = 0;
  bit mv [N];
  logic [31:0] mtag [N], mtgt [N];
  int mctr [N];
  int init_left = N;
  logic [31:0] mlc = '0, mhc = '0;
  typedef struct {
    logic [31:0] pc;
    bit uv;
    logic [31:0] upc, utgt;
    bit ut, eh;
    logic [31:0] ep;
  } vec_t;
  vec_t v [9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic void look(input logic [31:0] a, output bit h, output logic [31:0] t);
    int i = int'((a >> 2) % N);
    h = init_left == 0 && mv[i] && mtag[i] == (a >> 8) && (!CTR || mctr[i] >= 2);
    t = h ? mtgt[i] : 32'h0;
  endfunction
  task automatic model_edge(input bit h);
    int i;
    bit m;
    if (rst) begin
      init_left = N;
      mlc = '0;
      mhc = '0;
    end else if (init_left > 0) begin
      mv[N - init_left] = 1'b0;
      init_left--;
    end else begin
      if (!stall) begin
        mlc++;
        if (h) mhc++;
      end
      if (updateValid) begin
        i = int'((updatePc >> 2) % N);
        m = mv[i] && mtag[i] == (updatePc >> 8);
        if (updateTaken) begin
          mctr[i] = m ? (mctr[i] + 1 > 3 ? 3 : mctr[i] + 1) : 2;
          mv[i] = 1'b1;
          mtag[i] = updatePc >> 8;
          mtgt[i] = updateTarget;
        end else if (m) begin
          if (CTR) mctr[i] = mctr[i] - 1 < 0 ? 0 : mctr[i] - 1;
          else mv[i] = 1'b0;
        end
      end
    end
  endtask
  task automatic cycle();
    bit h;
    logic [31:0] t;
    #1;
    look(pc, h, t);
    chk("btbHit", btbHit, h);
    chk("btbPredictedPc", btbPredictedPc, t);
    chk("ready", ready, init_left == 0);
    chk("lookupCount", lookupCount, mlc);
    chk("hitCount", hitCount, mhc);
    @(posedge clk);
    model_edge(h);
    #1;
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    chk("ready_timeout", ready, 1);
  endtask
  task automatic drive(input logic [31:0] p, input bit uv, input logic [31:0] upc, input logic [31:0] utgt, input bit ut);
    pc = p;
    updateValid = uv;
    updatePc = upc;
    updateTarget = utgt;
    updateTaken = ut;
  endtask
  initial begin
    int n;
    logic [9:0] stp, mis;
    v[0] = '{32'h100, 1, 32'h100, 32'h200, 1, 0, 32'h0};
    v[1] = '{32'h100, 0, 32'h0, 32'h0, 0, 1, 32'h200};
    v[2] = '{32'h104, 0, 32'h0, 32'h0, 0, 0, 32'h0};
    v[3] = '{32'h100, 1, 32'h200, 32'h300, 1, 1, 32'h200};
    v[4] = '{32'h100, 0, 32'h0, 32'h0, 0, 0, 32'h0};
    v[5] = '{32'h200, 0, 32'h0, 32'h0, 0, 1, 32'h300};
    v[6] = '{32'h100, 1, 32'h100, 32'h200, 1, 0, 32'h0};
    v[7] = '{32'h100, 1, 32'h100, 32'h400, 1, 1, 32'h200};
    v[8] = '{32'h100, 0, 32'h0, 32'h0, 0, 1, 32'h400};
    pc = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    init_left = N;
    chk("rst_ready", ready, 0);
    chk("rst_lookupCount", lookupCount, 0);
    chk("rst_hitCount", hitCount, 0);
    chk("rst_btbHit", btbHit, 0);
    rst = 1'b0;
    drive(32'h100, 1, 32'h100, 32'h900, 1);
    repeat (10) cycle();
    updateValid = 1'b0;
    wait_ready(n);
    chk("init_len", n + 10, N);
    for (int i = 0; i < 9; i++) begin
      drive(v[i].pc, v[i].uv, v[i].upc, v[i].utgt, v[i].ut);
      #1;
      chk("tbl_hit", btbHit, v[i].eh);
      chk("tbl_pred", btbPredictedPc, v[i].ep);
      cycle();
    end
    drive(32'h500, 1, 32'h500, 32'h600, 1);
    cycle();
    drive(32'h500, 1, 32'h500, 32'h0, 0);
    #1;
    chk("nt_same_cycle_hit", btbHit, 1);
    cycle();
    drive(32'h500, 1, 32'h500, 32'h0, 0);
    #1;
    chk("nt_next_hit", btbHit, 0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(32'h500, 1, 32'h500, 32'h640, 1);
      cycle();
    end
    drive(32'h500, 1, 32'h500, 32'h0, 0);
    cycle();
    drive(32'h500, 0, 32'h0, 32'h0, 0);
    #1;
    chk("sat_hit", btbHit, CTR ? 1 : 0);
    chk("sat_pred", btbPredictedPc, CTR ? 32'h640 : 32'h0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wait_ready(n);
    chk("reinit_len", n, N);
    stp = 10'b0100100101;
    mis = 10'b1010010000;
    for (int i = 0; i < 10; i++) begin
      drive(mis[i] ? 32'h104 : 32'h100, i == 0, 32'h100, 32'h200, 1);
      stall = stp[i];
      cycle();
    end
    stall = 1'b0;
    chk("cnt_lookup", lookupCount, 6);
    chk("cnt_hit", hitCount, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("cnt_rst_lookup", lookupCount, 0);
    chk("cnt_rst_hit", hitCount, 0);
    chk("cnt_rst_ready", ready, 0);
    wait_ready(n);
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2),
            $urandom_range(0, 2) != 0,
            ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2),
            $urandom, $urandom_range(0, 2) != 0);
      stall = $urandom_range(0, 1) == 1;
      rst = $urandom_range(0, 399) == 0;
      cycle();
    end
    rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
